// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the round-robin lock arbiter.
//   - arb_state_e : controller state (IDLE / LOCK)
//   - onehot2bin  : one-hot to binary index, for vectors up to ARB_MAX_W wide
//   - rotl1       : rotate a vector of the given width left by one position
// Ports: none (package).
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Widest vector the helpers accept; callers zero-extend to this width
    // and pass their real width as an argument.
    localparam int unsigned ARB_MAX_W = 64;

    // OR-ing the indices of set bits is exact for one-hot input and
    // yields 0 for an all-zero vector.
    function automatic int unsigned onehot2bin(input logic [ARB_MAX_W-1:0] oh,
                                               input int unsigned          width);
        logic [ARB_MAX_W-1:0] tmp;
        int unsigned          idx;
        tmp = oh;
        idx = 0;
        for (int unsigned i = 0; i < ARB_MAX_W; i++) begin
            if (i < width && tmp[0]) begin
                idx |= i;
            end
            tmp = tmp >> 1;
        end
        return idx;
    endfunction

    // Bit width-1 wraps to bit 0; bits at or above width are cleared.
    function automatic logic [ARB_MAX_W-1:0] rotl1(input logic [ARB_MAX_W-1:0] v,
                                                   input int unsigned          width);
        logic [ARB_MAX_W-1:0] mask;
        mask = (width >= ARB_MAX_W) ? '1 : ((ARB_MAX_W'(1) << width) - ARB_MAX_W'(1));
        return ((v << 1) | (v >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/arbiter_fix_1.sv
// -----------------------------------------------------------------------------
// arbiter_fix_1
//   Combinational fixed-priority arbiter with a movable priority base.
//   The requester at the one-hot base position has highest priority, then
//   priority falls with increasing index, wrapping from REQ_NUM-1 to 0.
// Ports:
//   req  [REQ_NUM]  request vector
//   base [REQ_NUM]  one-hot highest-priority position
//   gnt  [REQ_NUM]  one-hot grant, zero when req is zero
// -----------------------------------------------------------------------------
module arbiter_fix_1 #(
    parameter int REQ_NUM = 4
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [REQ_NUM-1:0] base,
    output logic [REQ_NUM-1:0] gnt
);

    logic [2*REQ_NUM-1:0] req_dbl;
    logic [2*REQ_NUM-1:0] gnt_dbl;

    // Subtracting base from the doubled request vector clears the first set
    // bit at or above base (borrow chain); masking isolates that bit. Folding
    // the upper half back covers the wrap-around.
    assign req_dbl = {req, req};
    assign gnt_dbl = req_dbl & ~(req_dbl - {{REQ_NUM{1'b0}}, base});
    assign gnt     = gnt_dbl[REQ_NUM-1:0] | gnt_dbl[2*REQ_NUM-1:REQ_NUM];

endmodule

// File: rtl/arbiter_rr_lock.sv
// -----------------------------------------------------------------------------
// arbiter_rr_lock
//   Round-robin controller around arbiter_fix_1. Grants one source, holds the
//   grant for a multi-beat packet and rotates priority after each release.
//   Release: source drops req, or a beat with last, or MAX_HOLD beats.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   req      in   per-source level request
//   last     in   final beat of granted packet (used only on xfer)
//   ready    in   downstream accepts a beat
//   gnt      out  registered one-hot grant, zero when idle
//   gnt_id   out  binary index of gnt, zero when idle
//   gnt_vld  out  a grant is held
//   xfer     out  beat fires this cycle
// -----------------------------------------------------------------------------
module arbiter_rr_lock
    import arb_pkg::*;
#(
    parameter  int REQ_NUM  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(REQ_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] req,
    input  logic               last,
    input  logic               ready,
    output logic [REQ_NUM-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               gnt_vld,
    output logic               xfer
);

    localparam int            CW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW:0]   HOLD_LIM = (CW + 1)'(MAX_HOLD);

    arb_state_e         state, state_nxt;
    logic [REQ_NUM-1:0] base, base_nxt;
    logic [REQ_NUM-1:0] gnt_nxt;
    logic [REQ_NUM-1:0] fix_gnt;
    logic [CW-1:0]      beat_cnt, beat_cnt_nxt;
    logic               owner_req;
    logic               hold_hit;
    logic               release_now;

    arbiter_fix_1 #(.REQ_NUM(REQ_NUM)) u_fix (
        .req  (req),
        .base (base),
        .gnt  (fix_gnt)
    );

    assign gnt_vld = |gnt;
    assign gnt_id  = IDW'(onehot2bin(ARB_MAX_W'(gnt), REQ_NUM));

    // gnt is one-hot or zero, so this is req[gnt_id] gated by gnt_vld.
    assign owner_req = |(req & gnt);
    // Held grant must not produce a beat in the cycle reset is asserted.
    assign xfer      = owner_req & ready & ~rst;

    assign hold_hit  = (MAX_HOLD != 0) && (({1'b0, beat_cnt} + (CW + 1)'(1)) == HOLD_LIM);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_nxt    = state;
        gnt_nxt      = gnt;
        base_nxt     = base;
        beat_cnt_nxt = beat_cnt;
        release_now  = 1'b0;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt      = fix_gnt;
                    beat_cnt_nxt = '0;
                    state_nxt    = LOCK;
                end
            end
            LOCK: begin
                if (!owner_req) begin
                    release_now = 1'b1;
                end else if (xfer) begin
                    if (last || hold_hit) begin
                        release_now = 1'b1;
                    end else if (beat_cnt != '1) begin
                        // Saturates; only reachable when MAX_HOLD is 0.
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end

                if (release_now) begin
                    base_nxt     = REQ_NUM'(rotl1(ARB_MAX_W'(gnt), REQ_NUM));
                    gnt_nxt      = '0;
                    beat_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            base     <= REQ_NUM'(1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            base     <= base_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule
